// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-side memory controller, one load/store at a time from a word-addressed RAM
// with programmable latency. Define DMEM_MMIO_EN to map DataAddr[15:12]==4'hF onto IoIn/IoOut.
module data_mem_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
`ifdef DMEM_MMIO_EN
    input  logic [WORD_SIZE-1:0] IoIn,
    output logic [WORD_SIZE-1:0] IoOut,
`endif
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone
);

    // state | meaning
    // IDLE  | no access outstanding, DataDone=1, new request accepted
    // WAIT  | access latched, latency counter running, DataDone=0
    // DONE  | access completed this cycle, DataDone=1, new request accepted
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
    localparam bit         FAST_ALL = (LATENCY <= 1);

    state_t                 state;
    logic [3:0]             counter;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic [WORD_SIZE-1:0]   lat_data;
    logic                   lat_store;

    logic [WORD_SIZE-1:0]   mem [2**ADDR_BITS];

    logic                   req;
    logic                   accept;
    logic                   mmio_sel;
    logic                   fast;

    logic                   c_en;
    logic                   c_store;
    logic                   c_mmio;
    logic [ADDR_BITS-1:0]   c_addr;
    logic [WORD_SIZE-1:0]   c_data;
    logic                   ram_we;

    assign req    = ReadData | WriteData;
    assign accept = (state != WAIT) && req;

`ifdef DMEM_MMIO_EN
    assign mmio_sel = (DataAddr[WORD_SIZE-1 -: 4] == 4'hF);
`else
    logic unused_addr_hi;
    assign mmio_sel       = 1'b0;
    assign unused_addr_hi = ^DataAddr[WORD_SIZE-1:ADDR_BITS];
`endif

    // MMIO always completes on the accept edge; the latched path therefore only ever targets RAM.
    assign fast = FAST_ALL || mmio_sel;

    always_comb begin
        c_en    = 1'b0;
        c_store = 1'b0;
        c_mmio  = 1'b0;
        c_addr  = lat_addr;
        c_data  = lat_data;
        if (accept && fast) begin
            c_en    = 1'b1;
            c_store = WriteData;
            c_mmio  = mmio_sel;
            c_addr  = DataAddr[ADDR_BITS-1:0];
            c_data  = DataOut;
        end else if (state == WAIT && counter == 4'd1) begin
            c_en    = 1'b1;
            c_store = lat_store;
        end
    end

    // Reset on the completion edge drops the pending store.
    assign ram_we = !Reset && c_en && c_store && !c_mmio;

    always_ff @(posedge Clock) begin
        if (ram_we)
            mem[c_addr] <= c_data;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            counter  <= '0;
            DataDone <= 1'b1;
            DataIn   <= '0;
`ifdef DMEM_MMIO_EN
            IoOut    <= '0;
`endif
        end else begin
            case (state)
                WAIT: begin
                    if (counter == 4'd1) begin
                        state    <= DONE;
                        DataDone <= 1'b1;
                        counter  <= '0;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                default: begin
                    if (req) begin
                        lat_addr  <= DataAddr[ADDR_BITS-1:0];
                        lat_data  <= DataOut;
                        lat_store <= WriteData;
                        if (fast) begin
                            state    <= DONE;
                            DataDone <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            counter  <= LAT_LOAD;
                            DataDone <= 1'b0;
                        end
                    end else begin
                        state    <= IDLE;
                        DataDone <= 1'b1;
                    end
                end
            endcase

            if (c_en && !c_store) begin
`ifdef DMEM_MMIO_EN
                DataIn <= c_mmio ? IoIn : mem[c_addr];
`else
                DataIn <= mem[c_addr];
`endif
            end
`ifdef DMEM_MMIO_EN
            if (c_en && c_store && c_mmio)
                IoOut <= c_data;
`endif
        end
    end

endmodule
